dram_arbiter: RTL and testbench

Shares one data RAM (combinational read, single-cycle write, word-addressed by address>>2) between two bus masters: m0 is the CPU data port and m1 is the instruction port or a testbench loader. Masters use an Avalon-style read/write/waitrequest handshake with byteenable. Partial-word writes are done as an internal read-modify-write, because the RAM has no byte enables. The block sits between the masters and the RAM instance at the top of the test harness.

---
 rtl/dram_arb_pkg.sv | 28 ++
 rtl/dram_arbiter_if.sv | 24 ++
 rtl/dram_arbiter_byte_lane_merge.sv | 23 ++
 rtl/dram_arbiter.sv | 164 ++++++++++++++++
 tb/tb_dram_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dram_arb_pkg.sv
// Shared types for the two-master data RAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RMW,
        RESP
    } state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_t;

    localparam int NUM_LANES = 4;

    localparam logic [NUM_LANES-1:0] BE_FULL = {NUM_LANES{1'b1}};
    localparam logic [NUM_LANES-1:0] BE_NONE = {NUM_LANES{1'b0}};

    // A mask that is neither all-on nor all-off needs the read-modify-write path.
    function automatic logic is_partial(input logic [NUM_LANES-1:0] be);
        return (be != BE_FULL) && (be != BE_NONE);
    endfunction

endpackage

// File: rtl/dram_arbiter_if.sv
// Avalon-style master port: read/write request with byteenable, waitrequest completion.
// Latency: n/a (signal bundle only).
// Backpressure: slave holds waitrequest high until the transaction completes.
interface dram_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [3:0]        byteenable;
    logic              waitrequest;
    logic [31:0]       readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/dram_arbiter_byte_lane_merge.sv
// Merges enabled byte lanes of a new word over an old word.
// Latency: combinational.
// Backpressure: none.
module byte_lane_merge
    import dram_arb_pkg::*;
(
    input  logic [31:0]          old_word,
    input  logic [31:0]          new_word,
    input  logic [NUM_LANES-1:0] be,
    output logic [31:0]          merged
);

    // Lane k comes from new_word when its enable is set, otherwise keeps old_word.
    always_comb begin
        merged = old_word;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (be[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Two-master arbiter in front of a byte-enable-less RAM; partial writes become read-modify-write.
// Latency: read / full or empty write done 2 cycles after request seen in IDLE, partial write 3.
// Backpressure: waitrequest stays high except for one cycle when the granted master's transaction completes.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    dram_arbiter_if.slave     m0,
    dram_arbiter_if.slave     m1,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_read,
    output logic              ram_write,
    output logic [31:0]       ram_writedata,
    input  logic [31:0]       ram_readdata
);

    state_t                 state;
    logic                   gnt_id;
    op_t                    op_q;
    logic [31:0]            wdata_q;
    logic [NUM_LANES-1:0]   be_q;
    logic                   last_grant;
    logic                   ram_read_q;
    logic                   ram_write_q;
    logic                   wait0_q;
    logic                   wait1_q;
    logic [31:0]            rdata0_q;
    logic [31:0]            rdata1_q;
    logic [31:0]            merged;

    logic                   pend0;
    logic                   pend1;
    logic                   sel_vld;
    logic                   sel_id;
    op_t                    sel_op;
    logic [ADDR_W-1:0]      sel_addr;
    logic [31:0]            sel_wdata;
    logic [NUM_LANES-1:0]   sel_be;

    assign pend0 = m0.read | m0.write;
    assign pend1 = m1.read | m1.write;

    // Pick the next master: full arbitration in IDLE, only the other master in RESP.
    always_comb begin
        sel_vld = 1'b0;
        sel_id  = 1'b0;
        case (state)
            IDLE: begin
                sel_vld = pend0 | pend1;
                if (pend0 && pend1) begin
                    sel_id = RR_EN ? ~last_grant : 1'b0;
                end else begin
                    sel_id = pend1;
                end
            end
            RESP: begin
                sel_vld = gnt_id ? pend0 : pend1;
                sel_id  = ~gnt_id;
            end
            default: begin
                sel_vld = 1'b0;
                sel_id  = 1'b0;
            end
        endcase
    end

    // Mux the selected master's request; read+write together counts as a write.
    always_comb begin
        sel_op    = (sel_id ? m1.write : m0.write) ? OP_WRITE : OP_READ;
        sel_addr  = sel_id ? m1.address    : m0.address;
        sel_wdata = sel_id ? m1.writedata  : m0.writedata;
        sel_be    = sel_id ? m1.byteenable : m0.byteenable;
    end

    byte_lane_merge u_merge (
        .old_word (ram_readdata),
        .new_word (wdata_q),
        .be       (be_q),
        .merged   (merged)
    );

    // Arbiter state machine; every output is a register loaded on the state transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            gnt_id        <= 1'b0;
            op_q          <= OP_READ;
            wdata_q       <= '0;
            be_q          <= '0;
            last_grant    <= 1'b1;
            ram_read_q    <= 1'b0;
            ram_write_q   <= 1'b0;
            ram_address   <= '0;
            ram_writedata <= '0;
            wait0_q       <= 1'b1;
            wait1_q       <= 1'b1;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
        end else begin
            case (state)
                IDLE, RESP: begin
                    wait0_q     <= 1'b1;
                    wait1_q     <= 1'b1;
                    ram_read_q  <= 1'b0;
                    ram_write_q <= 1'b0;
                    if (sel_vld) begin
                        gnt_id      <= sel_id;
                        last_grant  <= sel_id;
                        op_q        <= sel_op;
                        wdata_q     <= sel_wdata;
                        be_q        <= sel_be;
                        ram_address <= sel_addr;
                        ram_read_q  <= (sel_op == OP_READ) || is_partial(sel_be);
                        if ((sel_op == OP_WRITE) && (sel_be == BE_FULL)) begin
                            ram_write_q   <= 1'b1;
                            ram_writedata <= sel_wdata;
                        end
                        state <= ACCESS;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    ram_read_q  <= 1'b0;
                    ram_write_q <= 1'b0;
                    if ((op_q == OP_WRITE) && is_partial(be_q)) begin
                        ram_write_q   <= 1'b1;
                        ram_writedata <= merged;
                        state         <= RMW;
                    end else begin
                        if (op_q == OP_READ) begin
                            if (gnt_id) rdata1_q <= ram_readdata;
                            else        rdata0_q <= ram_readdata;
                        end
                        wait0_q <= gnt_id;
                        wait1_q <= ~gnt_id;
                        state   <= RESP;
                    end
                end
                RMW: begin
                    ram_write_q <= 1'b0;
                    wait0_q     <= gnt_id;
                    wait1_q     <= ~gnt_id;
                    state       <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reset cancels any strobe in the same cycle, so an in-flight RMW never reaches the RAM.
    assign ram_read  = ram_read_q  & ~reset;
    assign ram_write = ram_write_q & ~reset;

    assign m0.waitrequest = wait0_q;
    assign m1.waitrequest = wait1_q;
    assign m0.readdata    = rdata0_q;
    assign m1.readdata    = rdata1_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: table of single transactions plus multi-cycle sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_dram_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dram_arbiter_if #(.ADDR_W(32)) m0_if ();
    dram_arbiter_if #(.ADDR_W(32)) m1_if ();
    dram_arbiter_if #(.ADDR_W(32)) f0_if ();
    dram_arbiter_if #(.ADDR_W(32)) f1_if ();

    logic [31:0] ram_address, ram_writedata, ram_readdata;
    logic        ram_read, ram_write;
    logic [31:0] f_address, f_writedata, f_readdata;
    logic        f_read, f_write;

    dram_arbiter #(.ADDR_W(32), .RR_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .m0(m0_if), .m1(m1_if),
        .ram_address(ram_address), .ram_read(ram_read), .ram_write(ram_write),
        .ram_writedata(ram_writedata), .ram_readdata(ram_readdata)
    );

    dram_arbiter #(.ADDR_W(32), .RR_EN(1'b0)) dut_fp (
        .clk(clk), .reset(reset), .m0(f0_if), .m1(f1_if),
        .ram_address(f_address), .ram_read(f_read), .ram_write(f_write),
        .ram_writedata(f_writedata), .ram_readdata(f_readdata)
    );

    assign f_readdata = 32'h5A5A_5A5A;

    logic [31:0] mem [0:255];
    assign ram_readdata = mem[ram_address[9:2]];
    always @(posedge clk) begin
        if (ram_write) mem[ram_address[9:2]] <= ram_writedata;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit d, input bit m, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        case ({d, m})
            2'b00: begin m0_if.read = rd; m0_if.write = wr; m0_if.address = a; m0_if.writedata = wd; m0_if.byteenable = be; end
            2'b01: begin m1_if.read = rd; m1_if.write = wr; m1_if.address = a; m1_if.writedata = wd; m1_if.byteenable = be; end
            2'b10: begin f0_if.read = rd; f0_if.write = wr; f0_if.address = a; f0_if.writedata = wd; f0_if.byteenable = be; end
            default: begin f1_if.read = rd; f1_if.write = wr; f1_if.address = a; f1_if.writedata = wd; f1_if.byteenable = be; end
        endcase
    endtask

    function automatic logic get_wait(input bit d, input bit m);
        case ({d, m})
            2'b00:   return m0_if.waitrequest;
            2'b01:   return m1_if.waitrequest;
            2'b10:   return f0_if.waitrequest;
            default: return f1_if.waitrequest;
        endcase
    endfunction

    function automatic logic [31:0] get_rdata(input bit d, input bit m);
        case ({d, m})
            2'b00:   return m0_if.readdata;
            2'b01:   return m1_if.readdata;
            2'b10:   return f0_if.readdata;
            default: return f1_if.readdata;
        endcase
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // kind: 0 = read, 1 = write, 2 = read and write together
    typedef struct {
        bit          m;
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          exp_lat;
        logic [31:0] exp_rd;
        int          exp_nrd;
        int          exp_nwr;
    } vec_t;

    task automatic run_txn(input vec_t v, output int lat, output logic [31:0] rd,
                           output int nrd, output int nwr, output bit both,
                           output logic [31:0] acc, output logic after_wait);
        lat = -1; rd = '0; nrd = 0; nwr = 0; both = 1'b0; acc = '0;
        drive(1'b0, v.m, v.kind != 2'd1, v.kind != 2'd0, v.addr, v.wdata, v.be);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); @(negedge clk);
            if (k == 1) acc = ram_address;
            if (ram_read) nrd++;
            if (ram_write) nwr++;
            if (ram_read && ram_write) both = 1'b1;
            if (!get_wait(1'b0, v.m)) begin
                lat = k;
                rd  = get_rdata(1'b0, v.m);
                break;
            end
        end
        drive(1'b0, v.m, 1'b0, 1'b0, '0, '0, '0);
        @(posedge clk); @(negedge clk);
        after_wait = get_wait(1'b0, v.m);
    endtask

    // Both selected masters issue one read each from IDLE; each drops its request on completion.
    task automatic round(input bit d, input bit u0, input bit u1,
                         output int id_a, output int cyc_a, output int id_b, output int cyc_b);
        int n = 0;
        bit done0 = !u0;
        bit done1 = !u1;
        id_a = -1; cyc_a = -1; id_b = -1; cyc_b = -1;
        drive(d, 1'b0, u0, 1'b0, 32'h10, '0, 4'hF);
        drive(d, 1'b1, u1, 1'b0, 32'h20, '0, 4'hF);
        for (int c = 1; c <= 12 && !(done0 && done1); c++) begin
            @(posedge clk); @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                if (!(m == 0 ? done0 : done1) && !get_wait(d, m[0])) begin
                    if (n == 0) begin id_a = m; cyc_a = c; end
                    else        begin id_b = m; cyc_b = c; end
                    n++;
                    if (m == 0) done0 = 1'b1; else done1 = 1'b1;
                    drive(d, m[0], 1'b0, 1'b0, '0, '0, '0);
                end
            end
        end
        @(posedge clk); @(negedge clk);
    endtask

    vec_t        vecs [15];
    logic [31:0] trk [2];

    initial begin
        int lat, nrd, nwr, ia, ca, ib, cb;
        logic [31:0] rd, acc;
        bit both, dbl;
        logic aw, w0, w1;
        int ids[$];
        int cyc[$];
        vec_t rv;

        //          m     kind  addr          wdata         be       lat rd            nrd nwr
        vecs[0]  = '{1'b1, 2'd1, 32'h0000_0100, 32'hFFFF_FFFF, 4'b1111, 2, 32'h0,         0, 1};
        vecs[1]  = '{1'b1, 2'd1, 32'h0000_0000, 32'hABCD_EF00, 4'b1111, 2, 32'h0,         0, 1};
        vecs[2]  = '{1'b0, 2'd0, 32'h0000_0100, 32'h0,         4'b1111, 2, 32'hFFFF_FFFF, 1, 0};
        vecs[3]  = '{1'b1, 2'd1, 32'h0000_0008, 32'h1234_5678, 4'b1111, 2, 32'h0,         0, 1};
        vecs[4]  = '{1'b1, 2'd0, 32'h0000_0008, 32'h0,         4'b1111, 2, 32'h1234_5678, 1, 0};
        vecs[5]  = '{1'b0, 2'd1, 32'h0000_0000, 32'h0000_00AA, 4'b0001, 3, 32'h0,         1, 1};
        vecs[6]  = '{1'b0, 2'd0, 32'h0000_0000, 32'h0,         4'b1111, 2, 32'hABCD_EFAA, 1, 0};
        vecs[7]  = '{1'b0, 2'd1, 32'h0000_0000, 32'hFFFF_FFFF, 4'b0000, 2, 32'h0,         0, 0};
        vecs[8]  = '{1'b1, 2'd0, 32'h0000_0000, 32'h0,         4'b1111, 2, 32'hABCD_EFAA, 1, 0};
        vecs[9]  = '{1'b1, 2'd1, 32'h0000_0004, 32'hAABB_CCDD, 4'b1111, 2, 32'h0,         0, 1};
        vecs[10] = '{1'b1, 2'd1, 32'h0000_0004, 32'h1122_3344, 4'b1010, 3, 32'h0,         1, 1};
        vecs[11] = '{1'b0, 2'd0, 32'h0000_0004, 32'h0,         4'b1111, 2, 32'h11BB_33DD, 1, 0};
        vecs[12] = '{1'b0, 2'd2, 32'h0000_000C, 32'hCAFE_BABE, 4'b1111, 2, 32'h0,         0, 1};
        vecs[13] = '{1'b1, 2'd0, 32'h0000_000C, 32'h0,         4'b1111, 2, 32'hCAFE_BABE, 1, 0};
        vecs[14] = '{1'b0, 2'd0, 32'h0000_0102, 32'h0,         4'b1111, 2, 32'hFFFF_FFFF, 1, 0};

        for (int d = 0; d < 2; d++)
            for (int m = 0; m < 2; m++)
                drive(d[0], m[0], 1'b0, 1'b0, '0, '0, '0);

        // Reset values
        do_reset();
        @(posedge clk); @(negedge clk);
        check("rst m0 wait",  m0_if.waitrequest, 1'b1);
        check("rst m1 wait",  m1_if.waitrequest, 1'b1);
        check("rst m0 rdata", m0_if.readdata, 32'h0);
        check("rst m1 rdata", m1_if.readdata, 32'h0);
        check("rst ram_read", ram_read, 1'b0);
        check("rst ram_write", ram_write, 1'b0);
        check("rst ram_address", ram_address, 32'h0);
        check("rst ram_writedata", ram_writedata, 32'h0);
        check("rst fp wait", {f0_if.waitrequest, f1_if.waitrequest}, 2'b11);

        // Single-transaction table
        trk[0] = '0; trk[1] = '0;
        for (int i = 0; i < 15; i++) begin
            rv = vecs[i];
            run_txn(rv, lat, rd, nrd, nwr, both, acc, aw);
            check($sformatf("v%0d latency", i), lat, rv.exp_lat);
            check($sformatf("v%0d ram_read count", i), nrd, rv.exp_nrd);
            check($sformatf("v%0d ram_write count", i), nwr, rv.exp_nwr);
            check($sformatf("v%0d ram_address", i), acc, rv.addr);
            check($sformatf("v%0d strobes overlap", i), both, 1'b0);
            check($sformatf("v%0d wait one cycle", i), aw, 1'b1);
            if (rv.kind == 2'd0) begin
                check($sformatf("v%0d readdata", i), rd, rv.exp_rd);
                trk[rv.m] = rv.exp_rd;
            end
            check($sformatf("v%0d m0 readdata held", i), m0_if.readdata, trk[0]);
            check($sformatf("v%0d m1 readdata held", i), m1_if.readdata, trk[1]);
        end

        // Round-robin with both masters requesting continuously
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h100, '0, 4'hF);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h008, '0, 4'hF);
        dbl = 1'b0;
        for (int c = 1; c <= 40 && ids.size() < 8; c++) begin
            @(posedge clk); @(negedge clk);
            w0 = m0_if.waitrequest;
            w1 = m1_if.waitrequest;
            if (!w0 && !w1) dbl = 1'b1;
            if (!w0) begin ids.push_back(0); cyc.push_back(c); end
            if (!w1) begin ids.push_back(1); cyc.push_back(c); end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0);
        @(posedge clk); @(negedge clk);
        check("rr completions", ids.size(), 8);
        check("rr dual completion", dbl, 1'b0);
        for (int i = 0; i < ids.size(); i++) begin
            check($sformatf("rr grant %0d", i), ids[i], i % 2);
            if (i == 0) check("rr first cycle", cyc[0], 2);
            else        check($sformatf("rr gap %0d", i), cyc[i] - cyc[i-1], 2);
        end
        check("rr m0 readdata", m0_if.readdata, 32'hFFFF_FFFF);
        check("rr m1 readdata", m1_if.readdata, 32'h1234_5678);

        // Round-robin from IDLE after m0 was last granted: m1 goes first
        round(1'b0, 1'b1, 1'b0, ia, ca, ib, cb);
        check("rr solo m0 id", ia, 0);
        check("rr solo m0 cycle", ca, 2);
        round(1'b0, 1'b1, 1'b1, ia, ca, ib, cb);
        check("rr idle first id", ia, 1);
        check("rr idle first cycle", ca, 2);
        check("rr idle second id", ib, 0);
        check("rr idle second cycle", cb, 4);

        // Fixed priority: m0 wins from IDLE even when it was granted last
        round(1'b1, 1'b1, 1'b1, ia, ca, ib, cb);
        check("fp r1 first id", ia, 0);
        check("fp r1 second id", ib, 1);
        round(1'b1, 1'b1, 1'b0, ia, ca, ib, cb);
        check("fp solo m0 id", ia, 0);
        round(1'b1, 1'b1, 1'b1, ia, ca, ib, cb);
        check("fp r3 first id", ia, 0);
        check("fp r3 first cycle", ca, 2);
        check("fp r3 second id", ib, 1);
        check("fp r3 second cycle", cb, 4);
        check("fp m0 readdata", f0_if.readdata, 32'h5A5A_5A5A);

        // Reset in the RMW cycle abandons the partial write
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h008, 32'h0000_00FF, 4'b0001);
        @(posedge clk); @(negedge clk);
        check("rmw access read", ram_read, 1'b1);
        @(posedge clk); @(negedge clk);
        check("rmw write strobe", ram_write, 1'b1);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        #1;
        check("rmw reset gates write", ram_write, 1'b0);
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        check("rmw reset m0 wait", m0_if.waitrequest, 1'b1);
        check("rmw reset m1 wait", m1_if.waitrequest, 1'b1);
        check("rmw reset strobes", {ram_read, ram_write}, 2'b00);
        @(posedge clk); @(negedge clk);
        rv = '{1'b1, 2'd0, 32'h0000_0008, 32'h0, 4'b1111, 2, 32'h1234_5678, 1, 0};
        run_txn(rv, lat, rd, nrd, nwr, both, acc, aw);
        check("post reset latency", lat, 2);
        check("post reset ram unchanged", rd, 32'h1234_5678);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
